// File: rtl/shift_arb2.sv
// Two-requester round-robin arbiter feeding one shared left barrel shifter,
// with a one-entry valid/ready result register. Optional SHIFT_ARB2_STATS_EN adds grant counters.
module shift_arb2 #(
    parameter int WIDTH = 16,
    parameter int AMTW  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [AMTW-1:0]  req0_amt,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [AMTW-1:0]  req1_amt,
    output logic [WIDTH-1:0] sh_inp,
    output logic [AMTW-1:0]  sh_amt,
    input  logic [WIDTH-1:0] sh_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
`ifdef SHIFT_ARB2_STATS_EN
    ,
    output logic [15:0]      grant_cnt0,
    output logic [15:0]      grant_cnt1
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [AMTW-1:0]  amt;
    } sh_req_t;

    logic    last_grant;
    logic    out_free;
    logic    grant0, grant1;
    logic    acc0, acc1, accept;
    sh_req_t sel;

    assign out_free = !res_valid | res_ready;

    // On a tie the requester that did not win the last accept goes next.
    assign grant0 = req0_valid & (!req1_valid |  last_grant);
    assign grant1 = req1_valid & (!req0_valid | !last_grant);

    assign req0_ready = grant0 & out_free;
    assign req1_ready = grant1 & out_free;

    assign acc0   = req0_valid & req0_ready;
    assign acc1   = req1_valid & req1_ready;
    assign accept = acc0 | acc1;

    // Shifter is driven from the grant alone so it keeps working while stalled.
    always_comb begin
        sel = '0;
        if (grant0)
            sel = '{data: req0_data, amt: req0_amt};
        else if (grant1)
            sel = '{data: req1_data, amt: req1_amt};
    end

    assign sh_inp = sel.data;
    assign sh_amt = sel.amt;

    always_ff @(posedge clk) begin
        if (rst) begin
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_id     <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            res_valid  <= 1'b1;
            res_data   <= sh_out;
            res_id     <= acc1;
            last_grant <= acc1;
        end else if (res_ready) begin
            res_valid  <= 1'b0;
        end
    end

`ifdef SHIFT_ARB2_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
        end else begin
            if (acc0 && grant_cnt0 != 16'hFFFF)
                grant_cnt0 <= grant_cnt0 + 16'd1;
            if (acc1 && grant_cnt1 != 16'hFFFF)
                grant_cnt1 <= grant_cnt1 + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_shift_arb2.sv
// Directed bench for shift_arb2; models the shared shifter and checks arbitration,
// backpressure, amount boundaries, reset and optional grant counters.
module tb_shift_arb2;

    localparam int WIDTH = 16;
    localparam int AMTW  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_data, req1_data;
    logic [AMTW-1:0]  req0_amt, req1_amt;
    logic [WIDTH-1:0] sh_inp, sh_out;
    logic [AMTW-1:0]  sh_amt;
    logic             res_valid, res_ready, res_id;
    logic [WIDTH-1:0] res_data;
`ifdef SHIFT_ARB2_STATS_EN
    logic [15:0]      grant_cnt0, grant_cnt1;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    // Shared shifter model: amounts past the width flush to zero.
    assign sh_out = (sh_amt >= 5'd16) ? '0 : (sh_inp << sh_amt);

    shift_arb2 #(.WIDTH(WIDTH), .AMTW(AMTW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_amt(req0_amt),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_amt(req1_amt),
        .sh_inp(sh_inp), .sh_amt(sh_amt), .sh_out(sh_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
`ifdef SHIFT_ARB2_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [15:0] bd_data [4] = '{16'hA5A5, 16'hFFFF, 16'hFFFF, 16'h0003};
    logic [4:0]  bd_amt  [4] = '{5'd0, 5'd16, 5'd31, 5'd15};
    logic [15:0] bd_exp  [4] = '{16'hA5A5, 16'h0000, 16'h0000, 16'h8000};

    initial begin
        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 0; req0_data = '0; req0_amt = '0;
        req1_valid = 0; req1_data = '0; req1_amt = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_data",  {16'd0, res_data},  32'd0);
        check("rst_id",    {31'd0, res_id},    32'd0);
        check("idle_sh_inp", {16'd0, sh_inp}, 32'd0);

        // Single request from requester 0.
        res_ready = 1'b1;
        req0_valid = 1; req0_data = 16'h00FF; req0_amt = 5'd4;
        #1;
        check("single_r0_ready", {31'd0, req0_ready}, 32'd1);
        check("single_r1_ready", {31'd0, req1_ready}, 32'd0);
        check("single_sh_amt",   {27'd0, sh_amt},     32'd4);
        tick();
        req0_valid = 0;
        check("single_valid", {31'd0, res_valid}, 32'd1);
        check("single_data",  {16'd0, res_data},  32'h0FF0);
        check("single_id",    {31'd0, res_id},    32'd0);
        tick();
        check("drain_valid", {31'd0, res_valid}, 32'd0);
        check("drain_hold",  {16'd0, res_data},  32'h0FF0);

        // Tie-break and alternation from a fresh reset.
        rst = 1; tick(); rst = 0;
        req0_valid = 1; req0_data = 16'h0001; req0_amt = 5'd1;
        req1_valid = 1; req1_data = 16'h0001; req1_amt = 5'd15;
        #1;
        check("tie_r0_ready", {31'd0, req0_ready}, 32'd1);
        check("tie_r1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        check("alt1_data", {16'd0, res_data}, 32'h0002);
        check("alt1_id",   {31'd0, res_id},   32'd0);
        check("alt1_r1_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        check("alt2_data", {16'd0, res_data}, 32'h8000);
        check("alt2_id",   {31'd0, res_id},   32'd1);
        tick();
        req0_valid = 0; req1_valid = 0;
        check("alt3_data", {16'd0, res_data}, 32'h0002);
        check("alt3_id",   {31'd0, res_id},   32'd0);

        // Backpressure with a result pending.
        res_ready = 0;
        req1_valid = 1; req1_data = 16'hFFFF; req1_amt = 5'd8;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_r1_ready", {31'd0, req1_ready}, 32'd0);
            check("bp_data",     {16'd0, res_data},   32'h0002);
            check("bp_valid",    {31'd0, res_valid},  32'd1);
            check("bp_sh_inp",   {16'd0, sh_inp},     32'hFFFF);
            tick();
        end
        res_ready = 1;
        #1;
        check("bp_release_ready", {31'd0, req1_ready}, 32'd1);
        tick();
        req1_valid = 0;
        check("bp_data_out", {16'd0, res_data}, 32'hFF00);
        check("bp_id_out",   {31'd0, res_id},   32'd1);

        // Amount boundaries, one accept per cycle.
        req0_valid = 1;
        for (int i = 0; i < 4; i++) begin
            req0_data = bd_data[i]; req0_amt = bd_amt[i];
            tick();
            check("amt_data", {16'd0, res_data}, {16'd0, bd_exp[i]});
            check("amt_id",   {31'd0, res_id},   32'd0);
        end
        req0_valid = 0;
        tick();

        // Reset mid-operation, with last_grant left at 0 beforehand.
        req0_valid = 1; req0_data = 16'h1234; req0_amt = 5'd0;
        tick();
        req0_valid = 0; res_ready = 0;
        check("pre_rst_valid", {31'd0, res_valid}, 32'd1);
        rst = 1; tick(); rst = 0;
        check("mid_rst_valid", {31'd0, res_valid}, 32'd0);
        check("mid_rst_data",  {16'd0, res_data},  32'd0);
        res_ready = 1;
        req0_valid = 1; req0_data = 16'h0001; req0_amt = 5'd2;
        req1_valid = 1; req1_data = 16'h0001; req1_amt = 5'd3;
        #1;
        check("post_rst_r0_ready", {31'd0, req0_ready}, 32'd1);
        check("post_rst_r1_ready", {31'd0, req1_ready}, 32'd0);
        tick();
        req0_valid = 0; req1_valid = 0;
        check("post_rst_id",   {31'd0, res_id},   32'd0);
        check("post_rst_data", {16'd0, res_data}, 32'h0004);

`ifdef SHIFT_ARB2_STATS_EN
        rst = 1; tick(); rst = 0;
        req0_valid = 1;
        for (int i = 0; i < 5; i++) tick();
        req0_valid = 0; req1_valid = 1;
        for (int i = 0; i < 3; i++) tick();
        req1_valid = 0;
        check("cnt0", {16'd0, grant_cnt0}, 32'd5);
        check("cnt1", {16'd0, grant_cnt1}, 32'd3);
        rst = 1; tick(); rst = 0;
        check("cnt0_rst", {16'd0, grant_cnt0}, 32'd0);
        check("cnt1_rst", {16'd0, grant_cnt1}, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
